// File: rtl/bicubic_tap_accumulate_pkg.sv
// Shared constants for the bicubic tap accumulation stage.
// Q11 kernel weights, four taps, 8-bit output pixels.
package bicubic_tap_accumulate_pkg;

  localparam int PROD_W  = 24;
  localparam int ACC_W   = 27;
  localparam int Q_FRAC  = 11;
  localparam int N_TAPS  = 4;
  localparam int PIX_MAX = 255;

  typedef struct packed {
    logic [7:0] pixel;
    logic       clip;
  } pix_t;

endpackage

// File: rtl/bicubic_tap_accumulate_if.sv
// Product-in / pixel-out handshake bundle of the tap accumulator.
// master drives products and out_ready; slave is the accumulator.
interface bicubic_tap_accumulate_if
  import bicubic_tap_accumulate_pkg::*;
#(
  parameter int PW = PROD_W
) ();

  logic                 in_clear;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [PW-1:0] in_product;
  logic                 out_valid;
  logic                 out_ready;
  logic [7:0]           out_pixel;
  logic                 out_clip;

  modport master (
    output in_clear, in_valid, in_product, out_ready,
    input  in_ready, out_valid, out_pixel, out_clip
  );

  modport slave (
    input  in_clear, in_valid, in_product, out_ready,
    output in_ready, out_valid, out_pixel, out_clip
  );

endinterface

// File: rtl/bicubic_round_clamp.sv
// Rounds a Q-format kernel sum (ties toward +inf) and clamps to 0..255.
// Shared by the horizontal and vertical passes.
module bicubic_round_clamp
  import bicubic_tap_accumulate_pkg::*;
#(
  parameter int ACC_WIDTH = ACC_W,
  parameter int FRAC_BITS = Q_FRAC
) (
  input  logic signed [ACC_WIDTH-1:0] sum_i,
  output logic [7:0]                  pixel_o,
  output logic                        clip_o
);

  localparam logic signed [ACC_WIDTH:0] HALF =
    {{(ACC_WIDTH-FRAC_BITS+1){1'b0}}, 1'b1, {(FRAC_BITS-1){1'b0}}};

  logic signed [ACC_WIDTH:0] biased;
  logic signed [ACC_WIDTH:0] r;
  logic                      under;
  logic                      over;

  // One guard bit so the rounding bias can never wrap the sum.
  assign biased = {sum_i[ACC_WIDTH-1], sum_i} + HALF;
  assign r      = biased >>> FRAC_BITS;
  assign under  = r[ACC_WIDTH];
  assign over   = !r[ACC_WIDTH] && (|r[ACC_WIDTH-1:8]);

  always_comb begin
    pixel_o = r[7:0];
    clip_o  = 1'b0;
    if (under) begin
      pixel_o = 8'd0;
      clip_o  = 1'b1;
    end else if (over) begin
      pixel_o = 8'(PIX_MAX);
      clip_o  = 1'b1;
    end
  end

endmodule

// File: rtl/bicubic_tap_accumulate.sv
// Serial 4-tap accumulator behind the stage-1 bicubic multiplier.
// Emits one rounded, clamped pixel per kernel on a valid/ready port.
module bicubic_tap_accumulate
  import bicubic_tap_accumulate_pkg::*;
#(
  parameter int INTER_PRODUCT_WIDTH = PROD_W,
  parameter int ACC_WIDTH           = ACC_W,
  parameter int FRAC_BITS           = Q_FRAC,
  parameter int TAPS                = N_TAPS
) (
  input  logic                    clk,
  input  logic                    rst,
  bicubic_tap_accumulate_if.slave bus
);

  localparam int TW = (TAPS > 1) ? $clog2(TAPS) : 1;

  logic [TW-1:0]               tap_cnt_q, tap_cnt_d;
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
  logic signed [ACC_WIDTH-1:0] prod_ext, sum;
  logic                        out_valid_q, out_valid_d;
  logic [7:0]                  out_pixel_q, out_pixel_d;
  logic                        out_clip_q, out_clip_d;
  logic                        in_rdy, in_fire, out_fire, last_tap;
  logic [7:0]                  rc_pixel;
  logic                        rc_clip;

  assign prod_ext = {
    {(ACC_WIDTH-INTER_PRODUCT_WIDTH){bus.in_product[INTER_PRODUCT_WIDTH-1]}},
    bus.in_product
  };

  // Stall only while a finished pixel is stuck in the output register.
  assign in_rdy = !(out_valid_q && !bus.out_ready);

  bicubic_round_clamp #(
    .ACC_WIDTH (ACC_WIDTH),
    .FRAC_BITS (FRAC_BITS)
  ) u_round_clamp (
    .sum_i   (sum),
    .pixel_o (rc_pixel),
    .clip_o  (rc_clip)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      tap_cnt_q   <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_pixel_q <= '0;
      out_clip_q  <= 1'b0;
    end else begin
      tap_cnt_q   <= tap_cnt_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_pixel_q <= out_pixel_d;
      out_clip_q  <= out_clip_d;
    end
  end

  always_comb begin
    in_fire     = bus.in_valid && in_rdy && !bus.in_clear;
    out_fire    = out_valid_q && bus.out_ready;
    last_tap    = in_fire && (tap_cnt_q == TW'(TAPS-1));
    sum         = ((tap_cnt_q == '0) ? '0 : acc_q) + prod_ext;
    tap_cnt_d   = tap_cnt_q;
    acc_d       = acc_q;
    out_valid_d = out_valid_q;
    out_pixel_d = out_pixel_q;
    out_clip_d  = out_clip_q;
    if (bus.in_clear) begin
      tap_cnt_d = '0;
      acc_d     = '0;
    end else if (in_fire) begin
      acc_d     = sum;
      tap_cnt_d = last_tap ? '0 : tap_cnt_q + TW'(1);
    end
    if (last_tap) begin
      out_valid_d = 1'b1;
      out_pixel_d = rc_pixel;
      out_clip_d  = rc_clip;
    end else if (out_fire) begin
      out_valid_d = 1'b0;
    end
  end

  always_comb begin
    bus.in_ready  = in_rdy;
    bus.out_valid = out_valid_q;
    bus.out_pixel = out_pixel_q;
    bus.out_clip  = out_clip_q;
  end

endmodule

// File: tb/tb_bicubic_tap_accumulate.sv
// Bench for bicubic_tap_accumulate: vector table, scoreboard,
// backpressure, clear and reset sequences, random kernels.
module tb_bicubic_tap_accumulate;
  import bicubic_tap_accumulate_pkg::*;

  typedef struct {
    int         p[4];
    logic [7:0] pix;
    logic       clip;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bicubic_tap_accumulate_if bus ();

  bicubic_tap_accumulate dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   checks = 0;
  int   passes = 0;
  pix_t sb[$];
  vec_t tbl[8];
  int   flat100[4];
  int   flat200[4];
  int   rk[4];

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act == req) passes++;
    else $display("FAIL %s: got %0d expected %0d", name, act, req);
  endtask

  function automatic pix_t model(input int p[4]);
    longint s;
    longint half;
    longint r;
    pix_t   e;
    s    = 0;
    half = 1;
    half = half << (Q_FRAC - 1);
    for (int i = 0; i < 4; i++) s += p[i];
    r = (s + half) >>> Q_FRAC;
    if (r < 0) e = '{pixel: 8'd0, clip: 1'b1};
    else if (r > 255) e = '{pixel: 8'd255, clip: 1'b1};
    else e = '{pixel: 8'(r), clip: 1'b0};
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_out", 1, 0);
      end else begin
        pix_t e;
        e = sb.pop_front();
        chk("out_pixel_clip", {bus.out_pixel, bus.out_clip},
            {e.pixel, e.clip});
      end
    end
  end

  task automatic beat(input int p, input bit clr);
    int n;
    n = 0;
    bus.in_valid   = 1'b1;
    bus.in_product = PROD_W'(p);
    bus.in_clear   = clr;
    forever begin
      @(negedge clk);
      if (bus.in_ready || clr) break;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b1;
      n++;
      if (n > 100) begin
        chk("beat_timeout", 0, 1);
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_clear = 1'b0;
  endtask

  task automatic kernel(input int p[4], input pix_t e, input bit lat);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) sb.push_back(e);
      beat(p[i], 1'b0);
      if (lat && i == 2) chk("latency_pre", bus.out_valid, 0);
      if (lat && i == 3) chk("latency_post", bus.out_valid, 1);
    end
  endtask

  initial begin
    flat100 = '{-2100, 23500, 198100, -14700};
    flat200 = '{-4200, 47000, 396200, -29400};
    tbl[0] = '{'{-2100, 23500, 198100, -14700}, 8'd100, 1'b0};
    tbl[1] = '{'{1024, 0, 0, 0}, 8'd1, 1'b0};
    tbl[2] = '{'{1023, 0, 0, 0}, 8'd0, 1'b0};
    tbl[3] = '{'{-57375, 0, 0, 0}, 8'd0, 1'b1};
    tbl[4] = '{'{505155, 59925, 0, 0}, 8'd255, 1'b1};
    tbl[5] = '{'{-1024, 0, 0, 0}, 8'd0, 1'b0};
    tbl[6] = '{'{-1025, 0, 0, 0}, 8'd0, 1'b1};
    tbl[7] = '{'{-4200, 47000, 396200, -29400}, 8'd200, 1'b0};

    bus.in_valid   = 1'b0;
    bus.in_clear   = 1'b0;
    bus.in_product = '0;
    bus.out_ready  = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_pixel", bus.out_pixel, 0);
    chk("rst_out_clip", bus.out_clip, 0);
    chk("rst_in_ready", bus.in_ready, 1);

    for (int i = 0; i < 8; i++)
      kernel(tbl[i].p, '{pixel: tbl[i].pix, clip: tbl[i].clip}, i == 0);
    @(posedge clk);
    #1;

    // Hold a finished pixel, prove the input stalls, then release.
    bus.out_ready = 1'b0;
    kernel(flat200, '{pixel: 8'd200, clip: 1'b0}, 1'b0);
    bus.in_valid   = 1'b1;
    bus.in_product = PROD_W'(flat100[0]);
    repeat (3) begin
      @(negedge clk);
      chk("hold_valid", bus.out_valid, 1);
      chk("hold_pixel", bus.out_pixel, 200);
      chk("stall_in_ready", bus.in_ready, 0);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    beat(flat100[0], 1'b0);
    chk("drain_with_beat", bus.out_valid, 0);
    beat(flat100[1], 1'b0);
    beat(flat100[2], 1'b0);
    sb.push_back('{pixel: 8'd100, clip: 1'b0});
    beat(flat100[3], 1'b0);
    @(posedge clk);
    #1;

    // Clear discards the partial sum and the coincident beat.
    beat(50000, 1'b0);
    beat(50000, 1'b0);
    beat(99999, 1'b1);
    kernel(flat100, '{pixel: 8'd100, clip: 1'b0}, 1'b0);
    @(posedge clk);
    #1;

    // Reset in the middle of a kernel.
    for (int i = 0; i < 3; i++) beat(30000, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_out_pixel", bus.out_pixel, 0);
    chk("midrst_out_clip", bus.out_clip, 0);
    chk("midrst_in_ready", bus.in_ready, 1);
    kernel(flat100, '{pixel: 8'd100, clip: 1'b0}, 1'b0);

    for (int k = 0; k < 20; k++) begin
      for (int i = 0; i < 4; i++)
        rk[i] = int'($urandom_range(0, 32'h7F_FFFF)) - 32'sh40_0000;
      sb.push_back(model(rk));
      for (int i = 0; i < 4; i++) begin
        bus.out_ready = ($urandom_range(0, 3) != 0);
        beat(rk[i], 1'b0);
      end
    end

    bus.out_ready = 1'b1;
    for (int n = 0; n < 20 && sb.size() != 0; n++) @(posedge clk);
    #1;
    chk("scoreboard_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
